// File: rtl/decode_if.sv
// Shared decode encodings plus the fetch/dispatch-facing decode bundle.
//
// decode_pkg : ALU operation codes, operand-source types and ENABLE/DISABLE.
// decode_if  : ir (instruction word, master -> slave) and every decode result
//              plus the sticky halted flag (slave -> master).
//   master : the fetch/dispatch side that presents ir and consumes results.
//   slave  : the decoder.

package decode_pkg;

    // ALU / memory / branch operation codes
    localparam logic [5:0] ALU_LB   = 6'd0;
    localparam logic [5:0] ALU_LH   = 6'd1;
    localparam logic [5:0] ALU_LW   = 6'd2;
    localparam logic [5:0] ALU_LBU  = 6'd3;
    localparam logic [5:0] ALU_LHU  = 6'd4;
    localparam logic [5:0] ALU_SB   = 6'd5;
    localparam logic [5:0] ALU_SH   = 6'd6;
    localparam logic [5:0] ALU_SW   = 6'd7;
    localparam logic [5:0] ALU_ADD  = 6'd8;
    localparam logic [5:0] ALU_SUB  = 6'd9;
    localparam logic [5:0] ALU_XOR  = 6'd10;
    localparam logic [5:0] ALU_OR   = 6'd11;
    localparam logic [5:0] ALU_AND  = 6'd12;
    localparam logic [5:0] ALU_SLL  = 6'd13;
    localparam logic [5:0] ALU_SRL  = 6'd14;
    localparam logic [5:0] ALU_SRA  = 6'd15;
    localparam logic [5:0] ALU_SLT  = 6'd16;
    localparam logic [5:0] ALU_SLTU = 6'd17;
    localparam logic [5:0] ALU_BEQ  = 6'd18;
    localparam logic [5:0] ALU_BNE  = 6'd19;
    localparam logic [5:0] ALU_BLT  = 6'd20;
    localparam logic [5:0] ALU_BGE  = 6'd21;
    localparam logic [5:0] ALU_BLTU = 6'd22;
    localparam logic [5:0] ALU_BGEU = 6'd23;
    localparam logic [5:0] ALU_JAL  = 6'd24;
    localparam logic [5:0] ALU_JALR = 6'd25;
    localparam logic [5:0] ALU_LUI  = 6'd26;
    localparam logic [5:0] ALU_NOP  = 6'd63;

    // Operand source selects
    localparam logic [1:0] OP_TYPE_NONE = 2'd0;
    localparam logic [1:0] OP_TYPE_REG  = 2'd1;
    localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
    localparam logic [1:0] OP_TYPE_PC   = 2'd3;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

interface decode_if;
    logic [31:0] ir;
    logic [4:0]  srcreg1_num;
    logic [4:0]  srcreg2_num;
    logic [4:0]  dstreg_num;
    logic [31:0] imm;
    logic [5:0]  alucode;
    logic [1:0]  aluop1_type;
    logic [1:0]  aluop2_type;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    logic        halted;

    modport master (
        output ir,
        input  srcreg1_num, srcreg2_num, dstreg_num, imm, alucode,
        input  aluop1_type, aluop2_type, reg_we, is_load, is_store, is_halt, halted
    );

    modport slave (
        input  ir,
        output srcreg1_num, srcreg2_num, dstreg_num, imm, alucode,
        output aluop1_type, aluop2_type, reg_we, is_load, is_store, is_halt, halted
    );
endinterface

// File: rtl/decode.sv
// RV32I instruction decoder, one instance per issue lane.
//
// Ports:
//   clk   : clock, only used by the sticky halted flag
//   rst_n : asynchronous active-low reset (clears halted)
//   dec   : decode_if.slave -- ir in; register numbers, immediate, alucode,
//           operand types, reg_we/is_load/is_store/is_halt and halted out.
// All decode results are combinational from ir. Undefined opcodes or funct
// combinations produce all-zero numbers/imm, ALU_NOP, OP_TYPE_NONE, no flags.

module decode
    import decode_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    decode_if.slave dec
);

    localparam logic [6:0]  OpcOp     = 7'b0110011;
    localparam logic [6:0]  OpcOpImm  = 7'b0010011;
    localparam logic [6:0]  OpcLui    = 7'b0110111;
    localparam logic [6:0]  OpcAuipc  = 7'b0010111;
    localparam logic [6:0]  OpcLoad   = 7'b0000011;
    localparam logic [6:0]  OpcStore  = 7'b0100011;
    localparam logic [6:0]  OpcBranch = 7'b1100011;
    localparam logic [6:0]  OpcJal    = 7'b1101111;
    localparam logic [6:0]  OpcJalr   = 7'b1100111;
    localparam logic [6:0]  OpcSystem = 7'b1110011;
    localparam logic [31:0] InsnEcall = 32'h0000_0073;

    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic        f7_zero, f7_alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

    assign ir      = dec.ir;
    assign opcode  = ir[6:0];
    assign funct3  = ir[14:12];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign rd      = ir[11:7];
    assign f7_zero = (ir[31:25] == 7'b0000000);
    assign f7_alt  = (ir[31:25] == 7'b0100000);

    assign imm_i     = {{20{ir[31]}}, ir[31:20]};
    assign imm_s     = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b     = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u     = {ir[31:12], 12'b0};
    assign imm_j     = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_shamt = {27'b0, ir[24:20]};

    logic        legal;
    logic        use_rs1, use_rs2, use_rd;
    logic [31:0] imm_raw;
    logic [5:0]  alu_raw;
    logic [1:0]  op1_raw, op2_raw;
    logic        load_raw, store_raw, halt_raw;

    always_comb begin
        legal     = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        imm_raw   = '0;
        alu_raw   = ALU_NOP;
        op1_raw   = OP_TYPE_NONE;
        op2_raw   = OP_TYPE_NONE;
        load_raw  = 1'b0;
        store_raw = 1'b0;
        halt_raw  = 1'b0;

        case (opcode)
            OpcOp: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                op1_raw = OP_TYPE_REG;
                op2_raw = OP_TYPE_REG;
                case (funct3)
                    3'b000:  alu_raw = f7_alt ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_raw = ALU_SLL;
                    3'b010:  alu_raw = ALU_SLT;
                    3'b011:  alu_raw = ALU_SLTU;
                    3'b100:  alu_raw = ALU_XOR;
                    3'b101:  alu_raw = f7_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_raw = ALU_OR;
                    default: alu_raw = ALU_AND;
                endcase
                // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding
                legal = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OpcOpImm: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                op1_raw = OP_TYPE_REG;
                op2_raw = OP_TYPE_IMM;
                imm_raw = imm_i;
                case (funct3)
                    3'b000: alu_raw = ALU_ADD;
                    3'b001: begin
                        alu_raw = ALU_SLL;
                        imm_raw = imm_shamt;
                        legal   = f7_zero;
                    end
                    3'b010: alu_raw = ALU_SLT;
                    3'b011: alu_raw = ALU_SLTU;
                    3'b100: alu_raw = ALU_XOR;
                    3'b101: begin
                        alu_raw = ir[30] ? ALU_SRA : ALU_SRL;
                        imm_raw = imm_shamt;
                        legal   = f7_zero || f7_alt;
                    end
                    3'b110:  alu_raw = ALU_OR;
                    default: alu_raw = ALU_AND;
                endcase
            end
            OpcLui: begin
                use_rd  = 1'b1;
                imm_raw = imm_u;
                alu_raw = ALU_LUI;
                op2_raw = OP_TYPE_IMM;
            end
            OpcAuipc: begin
                use_rd  = 1'b1;
                imm_raw = imm_u;
                alu_raw = ALU_ADD;
                op1_raw = OP_TYPE_IMM;
                op2_raw = OP_TYPE_PC;
            end
            OpcLoad: begin
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                imm_raw  = imm_i;
                op1_raw  = OP_TYPE_REG;
                op2_raw  = OP_TYPE_IMM;
                load_raw = 1'b1;
                case (funct3)
                    3'b000:  alu_raw = ALU_LB;
                    3'b001:  alu_raw = ALU_LH;
                    3'b010:  alu_raw = ALU_LW;
                    3'b100:  alu_raw = ALU_LBU;
                    3'b101:  alu_raw = ALU_LHU;
                    default: legal   = 1'b0;
                endcase
            end
            OpcStore: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                imm_raw   = imm_s;
                op1_raw   = OP_TYPE_REG;
                op2_raw   = OP_TYPE_IMM;
                store_raw = 1'b1;
                case (funct3)
                    3'b000:  alu_raw = ALU_SB;
                    3'b001:  alu_raw = ALU_SH;
                    3'b010:  alu_raw = ALU_SW;
                    default: legal   = 1'b0;
                endcase
            end
            OpcBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_raw = imm_b;
                op1_raw = OP_TYPE_REG;
                op2_raw = OP_TYPE_REG;
                case (funct3)
                    3'b000:  alu_raw = ALU_BEQ;
                    3'b001:  alu_raw = ALU_BNE;
                    3'b100:  alu_raw = ALU_BLT;
                    3'b101:  alu_raw = ALU_BGE;
                    3'b110:  alu_raw = ALU_BLTU;
                    3'b111:  alu_raw = ALU_BGEU;
                    default: legal   = 1'b0;
                endcase
            end
            OpcJal: begin
                use_rd  = 1'b1;
                imm_raw = imm_j;
                alu_raw = ALU_JAL;
                op2_raw = OP_TYPE_PC;
            end
            OpcJalr: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm_raw = imm_i;
                alu_raw = ALU_JALR;
                op1_raw = OP_TYPE_REG;
                op2_raw = OP_TYPE_PC;
                legal   = (funct3 == 3'b000);
            end
            OpcSystem: begin
                // ECALL doubles as halt; every other SYSTEM encoding is undefined
                halt_raw = 1'b1;
                legal    = (ir == InsnEcall);
            end
            default: legal = 1'b0;
        endcase
    end

    logic is_halt;
    assign is_halt = legal && halt_raw;

    // Illegal encodings collapse every output to its idle value
    assign dec.srcreg1_num = (legal && use_rs1) ? rs1 : 5'd0;
    assign dec.srcreg2_num = (legal && use_rs2) ? rs2 : 5'd0;
    assign dec.dstreg_num  = (legal && use_rd)  ? rd  : 5'd0;
    assign dec.imm         = legal ? imm_raw : 32'd0;
    assign dec.alucode     = legal ? alu_raw : ALU_NOP;
    assign dec.aluop1_type = legal ? op1_raw : OP_TYPE_NONE;
    assign dec.aluop2_type = legal ? op2_raw : OP_TYPE_NONE;
    assign dec.reg_we      = (legal && use_rd && (rd != 5'd0)) ? ENABLE : DISABLE;
    assign dec.is_load     = legal && load_raw;
    assign dec.is_store    = legal && store_raw;
    assign dec.is_halt     = is_halt;

    logic halted_d, halted_q;

    always_comb begin
        halted_d = halted_q | is_halt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign dec.halted = halted_q;

endmodule

// File: tb/tb_decode.sv
module tb_decode;
    import decode_pkg::*;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   n_checks;
    int   n_fail;

    decode_if bus ();

    decode u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  s1, s2, d;
        logic [31:0] imm;
        logic [5:0]  alu;
        logic [1:0]  t1, t2;
        logic        we, ld, st, hl;
    } exp_t;

    // Specification-level model: classify by opcode, look up operation in
    // funct3-indexed tables, build immediates with signed arithmetic.
    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        logic [5:0]  r_alu [8];
        logic [5:0]  l_alu [8];
        logic [5:0]  s_alu [8];
        logic [5:0]  b_alu [8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          ok, u1, u2, ud;
        r_alu = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        l_alu = '{ALU_LB, ALU_LH, ALU_LW, ALU_NOP, ALU_LBU, ALU_LHU, ALU_NOP, ALU_NOP};
        s_alu = '{ALU_SB, ALU_SH, ALU_SW, ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP};
        b_alu = '{ALU_BEQ, ALU_BNE, ALU_NOP, ALU_NOP, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 1; u1 = 0; u2 = 0; ud = 0;
        e = '{s1: 0, s2: 0, d: 0, imm: 0, alu: ALU_NOP, t1: OP_TYPE_NONE, t2: OP_TYPE_NONE,
              we: 0, ld: 0, st: 0, hl: 0};
        case (w[6:0])
            7'b0110011: begin
                u1 = 1; u2 = 1; ud = 1;
                e.t1 = OP_TYPE_REG; e.t2 = OP_TYPE_REG;
                if (f7 == 7'h00) e.alu = r_alu[f3];
                else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_SRA;
                else ok = 0;
            end
            7'b0010011: begin
                u1 = 1; ud = 1;
                e.t1 = OP_TYPE_REG; e.t2 = OP_TYPE_IMM;
                e.imm = int'($signed(w[31:20]));
                e.alu = r_alu[f3];
                if (f3 == 1 || f3 == 5) begin
                    e.imm = 32'(w[24:20]);
                    if (f3 == 1) ok = (f7 == 7'h00);
                    else ok = (f7 == 7'h00 || f7 == 7'h20);
                    if (f3 == 5 && w[30]) e.alu = ALU_SRA;
                end
            end
            7'b0110111: begin
                ud = 1; e.imm = {w[31:12], 12'h000}; e.alu = ALU_LUI;
                e.t2 = OP_TYPE_IMM;
            end
            7'b0010111: begin
                ud = 1; e.imm = {w[31:12], 12'h000}; e.alu = ALU_ADD;
                e.t1 = OP_TYPE_IMM; e.t2 = OP_TYPE_PC;
            end
            7'b0000011: begin
                u1 = 1; ud = 1; e.ld = 1;
                e.imm = int'($signed(w[31:20])); e.alu = l_alu[f3];
                e.t1 = OP_TYPE_REG; e.t2 = OP_TYPE_IMM;
                ok = (e.alu != ALU_NOP);
            end
            7'b0100011: begin
                u1 = 1; u2 = 1; e.st = 1;
                e.imm = int'($signed({w[31:25], w[11:7]})); e.alu = s_alu[f3];
                e.t1 = OP_TYPE_REG; e.t2 = OP_TYPE_IMM;
                ok = (e.alu != ALU_NOP);
            end
            7'b1100011: begin
                u1 = 1; u2 = 1;
                e.imm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                e.alu = b_alu[f3];
                e.t1 = OP_TYPE_REG; e.t2 = OP_TYPE_REG;
                ok = (e.alu != ALU_NOP);
            end
            7'b1101111: begin
                ud = 1;
                e.imm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                e.alu = ALU_JAL; e.t2 = OP_TYPE_PC;
            end
            7'b1100111: begin
                u1 = 1; ud = 1; ok = (f3 == 0);
                e.imm = int'($signed(w[31:20])); e.alu = ALU_JALR;
                e.t1 = OP_TYPE_REG; e.t2 = OP_TYPE_PC;
            end
            7'b1110011: begin
                ok = (w == 32'h0000_0073); e.hl = 1;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '{s1: 0, s2: 0, d: 0, imm: 0, alu: ALU_NOP, t1: OP_TYPE_NONE, t2: OP_TYPE_NONE,
                  we: 0, ld: 0, st: 0, hl: 0};
        end else begin
            e.s1 = u1 ? w[19:15] : 5'd0;
            e.s2 = u2 ? w[24:20] : 5'd0;
            e.d  = ud ? w[11:7] : 5'd0;
            e.we = ud && (w[11:7] != 0);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (ir=%h t=%0t)", name, act, exp, bus.ir, $time);
        end
    endtask

    // Reference halted flag: sticky on a decoded halt, cleared by reset
    logic exp_halted;
    initial exp_halted = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_halted <= 1'b0;
        else if (model(bus.ir).hl) exp_halted <= 1'b1;
    end

    exp_t m;
    always @(negedge clk) begin
        if (chk_en) begin
            m = model(bus.ir);
            chk("cmp_src1", 32'(bus.srcreg1_num), 32'(m.s1));
            chk("cmp_src2", 32'(bus.srcreg2_num), 32'(m.s2));
            chk("cmp_dst", 32'(bus.dstreg_num), 32'(m.d));
            chk("cmp_imm", bus.imm, m.imm);
            chk("cmp_alu", 32'(bus.alucode), 32'(m.alu));
            chk("cmp_op1", 32'(bus.aluop1_type), 32'(m.t1));
            chk("cmp_op2", 32'(bus.aluop2_type), 32'(m.t2));
            chk("cmp_flags", {28'd0, bus.reg_we, bus.is_load, bus.is_store, bus.is_halt},
                {28'd0, m.we, m.ld, m.st, m.hl});
            chk("cmp_halted", 32'(bus.halted), 32'(exp_halted));
        end
    end

    // Apply one instruction and check it against hand-computed values
    task automatic dir(input string nm, input logic [31:0] w,
                       input int s1, input int s2, input int d, input logic [31:0] im,
                       input logic [5:0] alu, input logic [1:0] t1, input logic [1:0] t2,
                       input logic we, input logic ld, input logic st, input logic hl);
        @(posedge clk);
        #1 bus.ir = w;
        #1;
        chk({nm, "_src1"}, 32'(bus.srcreg1_num), 32'(s1));
        chk({nm, "_src2"}, 32'(bus.srcreg2_num), 32'(s2));
        chk({nm, "_dst"}, 32'(bus.dstreg_num), 32'(d));
        chk({nm, "_imm"}, bus.imm, im);
        chk({nm, "_alu"}, 32'(bus.alucode), 32'(alu));
        chk({nm, "_op1"}, 32'(bus.aluop1_type), 32'(t1));
        chk({nm, "_op2"}, 32'(bus.aluop2_type), 32'(t2));
        chk({nm, "_flags"}, {28'd0, bus.reg_we, bus.is_load, bus.is_store, bus.is_halt},
            {28'd0, we, ld, st, hl});
    endtask

    localparam logic [1:0] N = OP_TYPE_NONE;
    localparam logic [1:0] R = OP_TYPE_REG;
    localparam logic [1:0] I = OP_TYPE_IMM;
    localparam logic [1:0] P = OP_TYPE_PC;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        bus.ir   = 32'h0000_0013;
        repeat (2) @(posedge clk);
        #1 chk("reset_halted", 32'(bus.halted), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        dir("add",   32'h00b50633, 10, 11, 12, 32'd0, ALU_ADD, R, R, 1, 0, 0, 0);
        dir("sub",   32'h40b50633, 10, 11, 12, 32'd0, ALU_SUB, R, R, 1, 0, 0, 0);
        dir("sra",   32'h40b5d7b3, 11, 11, 15, 32'd0, ALU_SRA, R, R, 1, 0, 0, 0);
        dir("add_x0", 32'h00b50033, 10, 11, 0, 32'd0, ALU_ADD, R, R, 0, 0, 0, 0);
        dir("addi",  32'hfff00513, 0, 0, 10, 32'hffffffff, ALU_ADD, R, I, 1, 0, 0, 0);
        dir("srai",  32'h4015d793, 11, 0, 15, 32'd1, ALU_SRA, R, I, 1, 0, 0, 0);
        dir("lui",   32'h808805b7, 0, 0, 11, 32'h80880000, ALU_LUI, N, I, 1, 0, 0, 0);
        dir("auipc", 32'h00000817, 0, 0, 16, 32'd0, ALU_ADD, I, P, 1, 0, 0, 0);
        dir("sb",    32'hfeb50fa3, 10, 11, 0, 32'hffffffff, ALU_SB, R, I, 0, 0, 1, 0);
        dir("lhu",   32'hffe55683, 10, 0, 13, 32'hfffffffe, ALU_LHU, R, I, 1, 1, 0, 0);
        dir("bltu",  32'hf8d66ce3, 12, 13, 0, 32'hffffff98, ALU_BLTU, R, R, 0, 0, 0, 0);
        dir("jal",   32'h00c0006f, 0, 0, 0, 32'd12, ALU_JAL, N, P, 0, 0, 0, 0);
        dir("jal_ra", 32'h00c000ef, 0, 0, 1, 32'd12, ALU_JAL, N, P, 1, 0, 0, 0);
        dir("jalr",  32'h008580e7, 11, 0, 1, 32'd8, ALU_JALR, R, P, 1, 0, 0, 0);
        // Undefined encodings: MUL funct7, load funct3=3, all-ones, EBREAK
        dir("bad_mul", 32'h02b50633, 0, 0, 0, 32'd0, ALU_NOP, N, N, 0, 0, 0, 0);
        dir("bad_ld",  32'h00053503, 0, 0, 0, 32'd0, ALU_NOP, N, N, 0, 0, 0, 0);
        dir("bad_ff",  32'hffffffff, 0, 0, 0, 32'd0, ALU_NOP, N, N, 0, 0, 0, 0);
        dir("ebreak",  32'h00100073, 0, 0, 0, 32'd0, ALU_NOP, N, N, 0, 0, 0, 0);
        chk("halted_pre", 32'(bus.halted), 32'd0);

        dir("ecall", 32'h00000073, 0, 0, 0, 32'd0, ALU_NOP, N, N, 0, 0, 0, 1);
        chk("halted_not_yet", 32'(bus.halted), 32'd0);
        @(posedge clk);
        #1 chk("halted_set", 32'(bus.halted), 32'd1);
        bus.ir = 32'h00b50633;
        repeat (3) @(posedge clk);
        #1 chk("halted_sticky", 32'(bus.halted), 32'd1);
        #3 rst_n = 1'b0;
        #1 chk("halted_async_clr", 32'(bus.halted), 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("halted_after_rst", 32'(bus.halted), 32'd0);

        // Reset held across an edge with ECALL presented: reset wins
        bus.ir = 32'h00000073;
        rst_n  = 1'b0;
        @(posedge clk);
        #1 chk("halted_rst_wins", 32'(bus.halted), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("halted_reset_then_set", 32'(bus.halted), 32'd1);
        bus.ir = 32'h00000013;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
